// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control unit.
// The state encoding is also what the debug port state_o shows.
package ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMRD    = 4'd3,
      MEMWB    = 4'd4,
      MEMWR    = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9
   } ctrl_state_t;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCB_RD2    = 2'b00;
   localparam logic [1:0] SRCB_EXTIMM = 2'b01;
   localparam logic [1:0] SRCB_FOUR   = 2'b10;

   localparam logic [1:0] FLAG_C = 2'd3;
   localparam logic [1:0] FLAG_N = 2'd2;
   localparam logic [1:0] FLAG_V = 2'd1;
   localparam logic [1:0] FLAG_Z = 2'd0;

   // ARM condition evaluation against packed {C,N,V,Z} flags.
   function automatic logic condHolds(input logic [3:0] cond, input logic [3:0] flags);
      logic c, n, v, z, ge;
      c  = flags[FLAG_C];
      n  = flags[FLAG_N];
      v  = flags[FLAG_V];
      z  = flags[FLAG_Z];
      ge = (n == v);
      case (cond)
         COND_EQ: condHolds = z;
         COND_NE: condHolds = ~z;
         COND_CS: condHolds = c;
         COND_CC: condHolds = ~c;
         COND_MI: condHolds = n;
         COND_PL: condHolds = ~n;
         COND_VS: condHolds = v;
         COND_VC: condHolds = ~v;
         COND_HI: condHolds = c & ~z;
         COND_LS: condHolds = ~c | z;
         COND_GE: condHolds = ge;
         COND_LT: condHolds = ~ge;
         COND_GT: condHolds = ~z & ge;
         COND_LE: condHolds = z | ~ge;
         COND_AL: condHolds = 1'b1;
         COND_NV: condHolds = 1'b0;
         default: condHolds = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_flag_reg.sv
// N/Z/C/V flag register with split write enables; the condition check
// always looks at the flags as they stand before this cycle's update.
module ctrl_flag_reg
   import ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] i_aluFlags,
   input  logic [1:0] i_flagW,
   input  logic [3:0] i_cond,
   output logic [3:0] o_flags,
   output logic       o_condEx
);

   logic [3:0] r_flags;
   logic [1:0] w_flagEn;

   assign o_condEx = condHolds(i_cond, r_flags);
   assign w_flagEn = i_flagW & {2{o_condEx}};
   assign o_flags  = r_flags;

   // Bit 1 of the enable owns N/Z, bit 0 owns C/V.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_flags <= 4'b0000;
      end else begin
         if (w_flagEn[1]) begin
            r_flags[FLAG_N] <= i_aluFlags[FLAG_N];
            r_flags[FLAG_Z] <= i_aluFlags[FLAG_Z];
         end
         if (w_flagEn[0]) begin
            r_flags[FLAG_C] <= i_aluFlags[FLAG_C];
            r_flags[FLAG_V] <= i_aluFlags[FLAG_V];
         end
      end
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control FSM for the ARM-subset CPU: sequences each instruction
// and gates every architectural write strobe with the condition result.
module multicycle_ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 4
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUControl,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc,
   output logic [3:0] Flags,
   output logic [3:0] state_o
);

   ctrl_state_t      r_state;
   ctrl_state_t      w_nextState;
   logic [CNT_W-1:0] r_waitCnt;
   logic             w_lastWait;
   logic             w_waitState;
   logic             w_nextPC;
   logic             w_irW;
   logic             w_regW;
   logic             w_memW;
   logic             w_branch;
   logic             w_condEx;
   logic [1:0]       w_flagW;
   logic [1:0]       w_aluDec;
   logic [1:0]       w_decFlagW;
   logic             w_cmdKnown;
   logic             w_cmdArith;

   assign w_lastWait  = (r_waitCnt == CNT_W'(MEM_LAT - 1));
   assign w_waitState = (r_state == FETCH) || (r_state == MEMRD) || (r_state == MEMWR);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= FETCH;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Leaving a wait state on its last cycle returns the count to zero, so
   // every wait state is entered with a cleared counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_waitCnt <= '0;
      end else if (w_waitState && !w_lastWait) begin
         r_waitCnt <= r_waitCnt + 1'b1;
      end else begin
         r_waitCnt <= '0;
      end
   end

   always_comb begin
      w_aluDec   = ALU_ADD;
      w_cmdKnown = 1'b1;
      w_cmdArith = 1'b0;
      case (Funct[4:1])
         CMD_ADD: begin w_aluDec = ALU_ADD; w_cmdArith = 1'b1; end
         CMD_SUB: begin w_aluDec = ALU_SUB; w_cmdArith = 1'b1; end
         CMD_AND: w_aluDec = ALU_AND;
         CMD_ORR: w_aluDec = ALU_ORR;
         default: w_cmdKnown = 1'b0;
      endcase
      w_decFlagW = {Funct[0] & w_cmdKnown, Funct[0] & w_cmdArith};
   end

   always_comb begin
      w_nextState = r_state;
      AdrSrc      = 1'b0;
      ResultSrc   = RES_ALUOUT;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_RD2;
      ALUControl  = ALU_ADD;
      w_nextPC    = 1'b0;
      w_irW       = 1'b0;
      w_regW      = 1'b0;
      w_memW      = 1'b0;
      w_branch    = 1'b0;
      w_flagW     = 2'b00;
      case (r_state)
         FETCH: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            w_nextPC  = w_lastWait;
            w_irW     = w_lastWait;
            if (w_lastWait) w_nextState = DECODE;
         end
         DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            case (Op)
               2'b01:   w_nextState = MEMADR;
               2'b00:   w_nextState = Funct[5] ? EXECUTEI : EXECUTER;
               2'b10:   w_nextState = BRANCH;
               default: w_nextState = FETCH;
            endcase
         end
         MEMADR: begin
            ALUSrcB     = SRCB_EXTIMM;
            w_nextState = Funct[0] ? MEMRD : MEMWR;
         end
         MEMRD: begin
            AdrSrc = 1'b1;
            if (w_lastWait) w_nextState = MEMWB;
         end
         MEMWB: begin
            ResultSrc   = RES_DATA;
            w_regW      = 1'b1;
            w_nextState = FETCH;
         end
         MEMWR: begin
            AdrSrc = 1'b1;
            w_memW = w_lastWait;
            if (w_lastWait) w_nextState = FETCH;
         end
         EXECUTER, EXECUTEI: begin
            ALUSrcB     = (r_state == EXECUTEI) ? SRCB_EXTIMM : SRCB_RD2;
            ALUControl  = w_aluDec;
            w_flagW     = w_decFlagW;
            w_nextState = ALUWB;
         end
         ALUWB: begin
            w_regW      = 1'b1;
            w_nextState = FETCH;
         end
         BRANCH: begin
            ALUSrcB     = SRCB_EXTIMM;
            ResultSrc   = RES_ALURESULT;
            w_branch    = 1'b1;
            w_nextState = FETCH;
         end
         default: w_nextState = FETCH;
      endcase
   end

   ctrl_flag_reg u_flagReg (
      .clk        (clk),
      .reset      (reset),
      .i_aluFlags (ALUFlags),
      .i_flagW    (w_flagW),
      .i_cond     (Cond),
      .o_flags    (Flags),
      .o_condEx   (w_condEx)
   );

   // Reset suppresses every write strobe immediately, not just at the next edge.
   assign PCWrite  = ~reset & (w_nextPC | (w_branch & w_condEx) |
                               (w_regW & w_condEx & (Rd == 4'b1111)));
   assign IRWrite  = ~reset & w_irW;
   assign RegWrite = ~reset & w_regW & w_condEx;
   assign MemWrite = ~reset & w_memW & w_condEx;

   assign ImmSrc  = Op;
   assign RegSrc  = {Op == 2'b01, Op == 2'b10};
   assign state_o = r_state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench: two DUTs (MEM_LAT=1 and MEM_LAT=3) share instruction
// inputs; expected per-cycle responses are queued and checked by a monitor.
module tb_multicycle_ctrl_fsm;
   import ctrl_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       resetA, resetB;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd, Cond, ALUFlags;

   logic       pcwA, adrA, memwA, irwA, regwA, srcaA;
   logic [1:0] resA, srcbA, alucA, immA, rsrcA;
   logic [3:0] flagsA, stateA;
   logic       pcwB, adrB, memwB, irwB, regwB, srcaB;
   logic [1:0] resB, srcbB, alucB, immB, rsrcB;
   logic [3:0] flagsB, stateB;

   multicycle_ctrl_fsm #(.MEM_LAT(1), .CNT_W(4)) dutA (
      .clk(clk), .reset(resetA), .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond),
      .ALUFlags(ALUFlags), .PCWrite(pcwA), .AdrSrc(adrA), .MemWrite(memwA),
      .IRWrite(irwA), .RegWrite(regwA), .ResultSrc(resA), .ALUSrcA(srcaA),
      .ALUSrcB(srcbA), .ALUControl(alucA), .ImmSrc(immA), .RegSrc(rsrcA),
      .Flags(flagsA), .state_o(stateA)
   );

   multicycle_ctrl_fsm #(.MEM_LAT(3), .CNT_W(4)) dutB (
      .clk(clk), .reset(resetB), .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond),
      .ALUFlags(ALUFlags), .PCWrite(pcwB), .AdrSrc(adrB), .MemWrite(memwB),
      .IRWrite(irwB), .RegWrite(regwB), .ResultSrc(resB), .ALUSrcA(srcaB),
      .ALUSrcB(srcbB), .ALUControl(alucB), .ImmSrc(immB), .RegSrc(rsrcB),
      .Flags(flagsB), .state_o(stateB)
   );

   typedef struct {
      logic       dutB;
      logic [3:0] state;
      logic [3:0] strobes;
      logic [3:0] flags;
      logic [1:0] aluc;
      int         id;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   stepId = 0;

   task automatic pushE(input logic dutSel, input ctrl_state_t st, input logic [3:0] strb,
                        input logic [3:0] fl, input logic [1:0] ac);
      exp_t e;
      e.dutB    = dutSel;
      e.state   = st;
      e.strobes = strb;
      e.flags   = fl;
      e.aluc    = ac;
      e.id      = stepId;
      stepId++;
      q.push_back(e);
   endtask

   task automatic applyStimulus(input logic [1:0] op, input logic [5:0] funct,
                                input logic [3:0] rd, input logic [3:0] cond,
                                input logic [3:0] aluFlags);
      Op       = op;
      Funct    = funct;
      Rd       = rd;
      Cond     = cond;
      ALUFlags = aluFlags;
   endtask

   // Strobe vector order is {PCWrite, IRWrite, RegWrite, MemWrite}.
   task automatic checkOutput(input exp_t e);
      logic [13:0] got, want;
      if (e.dutB)
         got = {stateB, pcwB, irwB, regwB, memwB, flagsB, alucB};
      else
         got = {stateA, pcwA, irwA, regwA, memwA, flagsA, alucA};
      want = {e.state, e.strobes, e.flags, e.aluc};
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL step%0d dut%s state/strobes/flags/aluc: got %0d/%b/%b/%b want %0d/%b/%b/%b",
                  e.id, e.dutB ? "B" : "A", got[13:10], got[9:6], got[5:2], got[1:0],
                  want[13:10], want[9:6], want[5:2], want[1:0]);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (q.size() > 0) checkOutput(q.pop_front());
      end
   end

   task automatic waitQueue(input int level);
      int n;
      n = 0;
      while (q.size() > level && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (q.size() > level) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain-timeout: got %0d entries left want %0d", q.size(), level);
         q.delete();
      end
   endtask

   initial begin
      resetA = 1'b1;
      resetB = 1'b1;
      applyStimulus(2'b00, 6'b001001, 4'd2, 4'hE, 4'b0001);
      repeat (2) @(posedge clk);
      #1;
      pushE(0, FETCH, 4'b0000, 4'b0000, 2'b00);
      waitQueue(0);
      @(posedge clk);
      #1 resetA = 1'b0;

      // ADD S=1, always: flags pick up Z
      pushE(0, FETCH,    4'b1100, 4'b0000, 2'b00);
      pushE(0, DECODE,   4'b0000, 4'b0000, 2'b00);
      pushE(0, EXECUTER, 4'b0000, 4'b0000, 2'b00);
      pushE(0, ALUWB,    4'b0010, 4'b0001, 2'b00);
      waitQueue(0);

      applyStimulus(2'b00, 6'b000101, 4'd2, 4'h1, 4'b1110);
      pushE(0, FETCH,    4'b1100, 4'b0001, 2'b00);
      pushE(0, DECODE,   4'b0000, 4'b0001, 2'b00);
      pushE(0, EXECUTER, 4'b0000, 4'b0001, 2'b01);
      pushE(0, ALUWB,    4'b0000, 4'b0001, 2'b00);
      waitQueue(0);

      applyStimulus(2'b10, 6'b100000, 4'd0, 4'h0, 4'b0000);
      pushE(0, FETCH,  4'b1100, 4'b0001, 2'b00);
      pushE(0, DECODE, 4'b0000, 4'b0001, 2'b00);
      pushE(0, BRANCH, 4'b1000, 4'b0001, 2'b00);
      waitQueue(0);

      applyStimulus(2'b00, 6'b001001, 4'd2, 4'hE, 4'b1010);
      pushE(0, FETCH,    4'b1100, 4'b0001, 2'b00);
      pushE(0, DECODE,   4'b0000, 4'b0001, 2'b00);
      pushE(0, EXECUTER, 4'b0000, 4'b0001, 2'b00);
      pushE(0, ALUWB,    4'b0010, 4'b1010, 2'b00);
      waitQueue(0);

      applyStimulus(2'b10, 6'b100000, 4'd0, 4'h0, 4'b0000);
      pushE(0, FETCH,  4'b1100, 4'b1010, 2'b00);
      pushE(0, DECODE, 4'b0000, 4'b1010, 2'b00);
      pushE(0, BRANCH, 4'b0000, 4'b1010, 2'b00);
      waitQueue(0);

      // AND S=1 to R15: N/Z only, and the write also redirects the PC
      applyStimulus(2'b00, 6'b000001, 4'hF, 4'hE, 4'b1100);
      pushE(0, FETCH,    4'b1100, 4'b1010, 2'b00);
      pushE(0, DECODE,   4'b0000, 4'b1010, 2'b00);
      pushE(0, EXECUTER, 4'b0000, 4'b1010, 2'b10);
      pushE(0, ALUWB,    4'b1010, 4'b1110, 2'b00);
      waitQueue(0);

      applyStimulus(2'b00, 6'b111000, 4'd3, 4'hE, 4'b0001);
      pushE(0, FETCH,    4'b1100, 4'b1110, 2'b00);
      pushE(0, DECODE,   4'b0000, 4'b1110, 2'b00);
      pushE(0, EXECUTEI, 4'b0000, 4'b1110, 2'b11);
      pushE(0, ALUWB,    4'b0010, 4'b1110, 2'b00);
      waitQueue(0);

      resetA = 1'b1;
      pushE(1, FETCH, 4'b0000, 4'b0000, 2'b00);
      waitQueue(0);
      applyStimulus(2'b01, 6'b011001, 4'd4, 4'hE, 4'b0000);
      @(posedge clk);
      #1 resetB = 1'b0;

      // LDR with three-cycle memory
      pushE(1, FETCH,  4'b0000, 4'b0000, 2'b00);
      pushE(1, FETCH,  4'b0000, 4'b0000, 2'b00);
      pushE(1, FETCH,  4'b1100, 4'b0000, 2'b00);
      pushE(1, DECODE, 4'b0000, 4'b0000, 2'b00);
      pushE(1, MEMADR, 4'b0000, 4'b0000, 2'b00);
      pushE(1, MEMRD,  4'b0000, 4'b0000, 2'b00);
      pushE(1, MEMRD,  4'b0000, 4'b0000, 2'b00);
      pushE(1, MEMRD,  4'b0000, 4'b0000, 2'b00);
      pushE(1, MEMWB,  4'b0010, 4'b0000, 2'b00);
      waitQueue(0);

      applyStimulus(2'b01, 6'b011000, 4'd4, 4'hE, 4'b0000);
      pushE(1, FETCH,  4'b0000, 4'b0000, 2'b00);
      pushE(1, FETCH,  4'b0000, 4'b0000, 2'b00);
      pushE(1, FETCH,  4'b1100, 4'b0000, 2'b00);
      pushE(1, DECODE, 4'b0000, 4'b0000, 2'b00);
      pushE(1, MEMADR, 4'b0000, 4'b0000, 2'b00);
      pushE(1, MEMWR,  4'b0000, 4'b0000, 2'b00);
      pushE(1, MEMWR,  4'b0000, 4'b0000, 2'b00);
      pushE(1, MEMWR,  4'b0001, 4'b0000, 2'b00);
      waitQueue(0);

      applyStimulus(2'b00, 6'b001001, 4'd2, 4'hE, 4'b1111);
      pushE(1, FETCH,    4'b0000, 4'b0000, 2'b00);
      pushE(1, FETCH,    4'b0000, 4'b0000, 2'b00);
      pushE(1, FETCH,    4'b1100, 4'b0000, 2'b00);
      pushE(1, DECODE,   4'b0000, 4'b0000, 2'b00);
      pushE(1, EXECUTER, 4'b0000, 4'b0000, 2'b00);
      pushE(1, ALUWB,    4'b0010, 4'b1111, 2'b00);
      waitQueue(0);

      // STR aborted by reset in its final MEMWR cycle
      applyStimulus(2'b01, 6'b011000, 4'd4, 4'hE, 4'b0000);
      pushE(1, FETCH,  4'b0000, 4'b1111, 2'b00);
      pushE(1, FETCH,  4'b0000, 4'b1111, 2'b00);
      pushE(1, FETCH,  4'b1100, 4'b1111, 2'b00);
      pushE(1, DECODE, 4'b0000, 4'b1111, 2'b00);
      pushE(1, MEMADR, 4'b0000, 4'b1111, 2'b00);
      pushE(1, MEMWR,  4'b0000, 4'b1111, 2'b00);
      pushE(1, MEMWR,  4'b0000, 4'b1111, 2'b00);
      pushE(1, FETCH,  4'b0000, 4'b0000, 2'b00);
      waitQueue(1);
      @(posedge clk);
      #1 resetB = 1'b1;
      waitQueue(0);

      applyStimulus(2'b11, 6'b000000, 4'd0, 4'hE, 4'b0000);
      @(posedge clk);
      #1 resetB = 1'b0;
      pushE(1, FETCH,  4'b0000, 4'b0000, 2'b00);
      pushE(1, FETCH,  4'b0000, 4'b0000, 2'b00);
      pushE(1, FETCH,  4'b1100, 4'b0000, 2'b00);
      pushE(1, DECODE, 4'b0000, 4'b0000, 2'b00);
      waitQueue(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
